// File: rtl/lns_to_linear_pipe.sv
// lns_to_linear_pipe: converts an LNS word (signed Q8.9 log2 magnitude plus sign)
// into a signed Q16.16 linear value. Three stages: field decode, 2^f mantissa from
// an interpolated table, then barrel shift, saturation and sign application.
// A single enable advances the whole pipe; it stalls only when the output is full
// and not being taken.
module lns_to_linear_pipe #(
  parameter int bit_size = 18,
  parameter int frac     = 9,
  parameter int LUT_BITS = 5,
  parameter int OUT_W    = 32,
  parameter int OUT_FRAC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bit_size-1:0] X,
  input  logic                Sx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    Z_lin,
  output logic                ovf
);

  localparam int IW   = bit_size - frac;        // integer part of the log
  localparam int RW   = frac - LUT_BITS;        // interpolation fraction bits
  localparam int MF   = OUT_FRAC;               // mantissa fraction bits
  localparam int MW   = MF + 2;                 // mantissa width, covers [1.0, 2.0]
  localparam int IMAX = OUT_W - OUT_FRAC - 1;   // first exponent that always saturates
  localparam int PW   = MW + RW;                // interpolation product width

  localparam logic signed [IW-1:0] I_SAT     = IW'(IMAX);
  localparam logic signed [IW-1:0] I_MIN     = IW'(-(MF + 1));
  localparam logic [OUT_W-1:0]     MAXPOS    = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [bit_size-1:0]  ZERO_CODE = {1'b1, {(bit_size-1){1'b0}}};

  // round(2^(j/32) * 2^16), j = 0..32
  function automatic logic [MW-1:0] exp2_lut(input logic [LUT_BITS:0] j);
    logic [MW-1:0] t;
    t = '0;
    case (j)
      6'd0:  t = 18'd65536;
      6'd1:  t = 18'd66971;
      6'd2:  t = 18'd68438;
      6'd3:  t = 18'd69936;
      6'd4:  t = 18'd71468;
      6'd5:  t = 18'd73032;
      6'd6:  t = 18'd74632;
      6'd7:  t = 18'd76266;
      6'd8:  t = 18'd77936;
      6'd9:  t = 18'd79642;
      6'd10: t = 18'd81386;
      6'd11: t = 18'd83169;
      6'd12: t = 18'd84990;
      6'd13: t = 18'd86851;
      6'd14: t = 18'd88752;
      6'd15: t = 18'd90696;
      6'd16: t = 18'd92682;
      6'd17: t = 18'd94711;
      6'd18: t = 18'd96785;
      6'd19: t = 18'd98905;
      6'd20: t = 18'd101070;
      6'd21: t = 18'd103283;
      6'd22: t = 18'd105545;
      6'd23: t = 18'd107856;
      6'd24: t = 18'd110218;
      6'd25: t = 18'd112631;
      6'd26: t = 18'd115098;
      6'd27: t = 18'd117618;
      6'd28: t = 18'd120194;
      6'd29: t = 18'd122825;
      6'd30: t = 18'd125515;
      6'd31: t = 18'd128263;
      6'd32: t = 18'd131072;
      default: t = '0;
    endcase
    return t;
  endfunction

  // Linear interpolation between adjacent table points; the fractional step truncates.
  function automatic logic [MW-1:0] interp(input logic [MW-1:0] t_lo,
                                           input logic [MW-1:0] t_hi,
                                           input logic [RW-1:0] r);
    logic [MW-1:0] diff;
    logic [PW-1:0] prod;
    diff = t_hi - t_lo;
    prod = PW'(diff) * PW'(r);
    return t_lo + MW'(prod >> RW);
  endfunction

  // Scale the mantissa by 2^i; returns {ovf, magnitude}. Right shifts truncate,
  // tiny values flush to zero without a flag, large values clamp to MAXPOS.
  function automatic logic [OUT_W:0] scale(input logic signed [IW-1:0] i,
                                           input logic [MW-1:0]        m,
                                           input logic                 zero);
    logic [OUT_W:0]   wide;
    logic [IW-1:0]    nsh;
    logic [OUT_W-1:0] mag;
    logic             o;
    wide = '0;
    nsh  = '0;
    mag  = '0;
    o    = 1'b0;
    if (zero) begin
      mag = '0;
    end else if (i >= I_SAT) begin
      mag = MAXPOS;
      o   = 1'b1;
    end else if (i >= 0) begin
      wide = (OUT_W+1)'(m) << $unsigned(i);
      if (wide > {1'b0, MAXPOS}) begin
        mag = MAXPOS;
        o   = 1'b1;
      end else begin
        mag = wide[OUT_W-1:0];
      end
    end else if (i > I_MIN) begin
      nsh = $unsigned(-i);
      mag = OUT_W'(m >> nsh);
    end else begin
      mag = '0;
    end
    return {o, mag};
  endfunction

  // Apply the sign; magnitude never exceeds MAXPOS so negation cannot wrap.
  function automatic logic [OUT_W-1:0] apply_sign(input logic [OUT_W-1:0] mag,
                                                  input logic             s);
    return s ? (~mag + 1'b1) : mag;
  endfunction

  logic en;
  logic vld_p0, vld_p1, vld_p2;

  logic signed [IW-1:0] i_p0;
  logic [LUT_BITS-1:0]  k_p0;
  logic [RW-1:0]        r_p0;
  logic                 sx_p0, zero_p0;

  logic signed [IW-1:0] i_p1;
  logic [MW-1:0]        m_p1;
  logic                 sx_p1, zero_p1;

  logic [MW-1:0]        t_lo_s2, t_hi_s2, m_s2;
  logic [OUT_W:0]       sc_s3;

  assign en        = !vld_p2 || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2;

  // Valid bits advance together with the data whenever the pipe is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: split X into exponent, table index and interpolation fraction ----
  // Decode register; carries the zero-code flag so later stages need not see X.
  always_ff @(posedge clk) begin
    if (en) begin
      i_p0    <= X[bit_size-1:frac];
      k_p0    <= X[frac-1:frac-LUT_BITS];
      r_p0    <= X[RW-1:0];
      sx_p0   <= Sx;
      zero_p0 <= (X == ZERO_CODE);
    end
  end

  // ---- stage 2: mantissa M = 2^f from table plus interpolation ----
  assign t_lo_s2 = exp2_lut({1'b0, k_p0});
  assign t_hi_s2 = exp2_lut({1'b0, k_p0} + (LUT_BITS+1)'(1));
  assign m_s2    = interp(t_lo_s2, t_hi_s2, r_p0);

  // Mantissa register.
  always_ff @(posedge clk) begin
    if (en) begin
      i_p1    <= i_p0;
      m_p1    <= m_s2;
      sx_p1   <= sx_p0;
      zero_p1 <= zero_p0;
    end
  end

  // ---- stage 3: shift by exponent, saturate, sign ----
  assign sc_s3 = scale(i_p1, m_p1, zero_p1);

  // Output register; loads only real samples so a held result stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      Z_lin <= '0;
      ovf   <= 1'b0;
    end else if (en && vld_p1) begin
      Z_lin <= apply_sign(sc_s3[OUT_W-1:0], sx_p1);
      ovf   <= sc_s3[OUT_W];
    end
  end

endmodule

// File: tb/tb_lns_to_linear_pipe.sv
// Directed bench for lns_to_linear_pipe: single-sample conversions with latency,
// backpressure, throughput and mid-stream reset.
module tb_lns_to_linear_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] X;
  logic        Sx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z_lin;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lns_to_linear_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Sx        (Sx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z_lin     (Z_lin),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One sample through an empty pipe: not visible after 2 edges, visible after 3.
  task automatic run_vec(input string tag, input logic [17:0] x, input logic s,
                         input logic [31:0] ez, input logic eo);
    @(negedge clk);
    X = x; Sx = s; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_z"},   Z_lin, ez);
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int          idx, got, cnt;
    logic        acc, take;
    logic [31:0] obs [5];
    logic [7:0]  pat;
    logic [31:0] zc6;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; Sx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld",   {31'd0, out_valid}, 32'd0);
    chk("rst_z",     Z_lin, 32'd0);
    chk("rst_ovf",   {31'd0, ovf}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    run_vec("one",      18'h00000, 1'b0, 32'h0001_0000, 1'b0);
    run_vec("two",      18'h00200, 1'b0, 32'h0002_0000, 1'b0);
    run_vec("neg_half", 18'h3FE00, 1'b1, 32'hFFFF_8000, 1'b0);
    run_vec("sqrt2",    18'h00100, 1'b0, 32'h0001_6A0A, 1'b0);
    run_vec("interp16", 18'h00108, 1'b0, 32'h0001_6E00, 1'b0);
    run_vec("interp31", 18'h001FF, 1'b0, 32'h0001_FF50, 1'b0);
    run_vec("i14",      18'h01C00, 1'b0, 32'h4000_0000, 1'b0);
    run_vec("i14_max",  18'h01DFF, 1'b0, 32'h7FD4_0000, 1'b0);
    run_vec("sat_pos",  18'h01E00, 1'b0, 32'h7FFF_FFFF, 1'b1);
    run_vec("sat_neg",  18'h01E00, 1'b1, 32'h8000_0001, 1'b1);
    run_vec("zero_p",   18'h20000, 1'b0, 32'h0000_0000, 1'b0);
    run_vec("zero_n",   18'h20000, 1'b1, 32'h0000_0000, 1'b0);
    run_vec("tiny66",   18'h37C00, 1'b0, 32'h0000_0000, 1'b0);
    run_vec("im16",     18'h3E000, 1'b0, 32'h0000_0001, 1'b0);
    run_vec("im16_neg", 18'h3E000, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_vec("im16_f",   18'h3E1FF, 1'b0, 32'h0000_0001, 1'b0);
    run_vec("im17",     18'h3DE00, 1'b0, 32'h0000_0000, 1'b0);

    // Backpressure: five samples offered with the output blocked.
    @(negedge clk);
    idx = 0; out_ready = 1'b0; Sx = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (idx < 5); X = {9'(idx), 9'd0};
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    #1;
    chk("bp_accepted", 32'(idx), 32'd3);
    chk("bp_ready",    {31'd0, in_ready}, 32'd0);
    chk("bp_vld",      {31'd0, out_valid}, 32'd1);
    chk("bp_hold_z",   Z_lin, 32'h0001_0000);
    in_valid = 1'b0;

    // Release: everything drains in order while the rest is fed in.
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (idx < 5); X = {9'(idx), 9'd0};
      #1;
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (take && got < 5) obs[got] = Z_lin;
      @(posedge clk);
      if (acc) idx++;
      if (take) got++;
    end
    in_valid = 1'b0;
    chk("bp_got", 32'(got), 32'd5);
    chk("bp_fed", 32'(idx), 32'd5);
    for (int j = 0; j < 5; j++) chk($sformatf("bp_out%0d", j), obs[j], 32'h0001_0000 << j);
    @(negedge clk);
    #1;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Throughput: four back-to-back samples leave on four consecutive cycles.
    pat = '0; zc6 = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = (c < 4); X = {9'(c), 9'd0};
      #1;
      pat[c] = out_valid;
      if (c == 6) zc6 = Z_lin;
      @(posedge clk);
    end
    in_valid = 1'b0;
    chk("tp_pattern", {24'd0, pat}, 32'h0000_0078);
    chk("tp_z_last",  zc6, 32'h0008_0000);

    // Reset with three samples in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; X = 18'h00400; Sx = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_vld_pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_z",   Z_lin, 32'd0);
    chk("mid_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("mid_stale", 32'(cnt), 32'd0);
    chk("mid_ready", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
